alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU control decoder.
- Decodes ALUOp/Funct7/Funct3 into a 4-bit operation and executes it on XLEN-bit operands.
- Adds iterative unsigned multiply/divide (Funct7=0000001), an illegal-op flag and valid/ready handshakes on both sides.
- Sits in the execute stage between the register-read pipeline register and writeback.

Parameters:
- XLEN, 32, operand/result width; legal values 8..64, must be a power of two.
- MULDIV_EN, 1, when 1 the M ops are implemented; when 0 they decode as illegal.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request this cycle
- ALUOp  in  2  00 I-type, 01 load/store, 10 R-type
- Funct7  in  7  instruction funct7
- Funct3  in  3  instruction funct3
- op_a  in  XLEN  operand A (rs1)
- op_b  in  XLEN  operand B (rs2 or immediate)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- result  out  XLEN  result
- operation  out  4  decoded operation code for the held result
- illegal  out  1  held request did not decode

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE.
  - out_valid=0, result=0, operation=0000, illegal=0, count=0.
  - in_ready is low during reset.
- Decode is combinational from inputs and is captured on acceptance. No output is ever X.
- Decode with ALUOp=10 and Funct7=0000000:
  - Funct3 111 AND 0000; 110 OR 0001; 100 NOR 1100; 010 SLT 0111; 000 ADD 0010.
- ALUOp=10, Funct7=0100000, Funct3=000: SUB 0110.
- ALUOp=10, Funct7=0000001, MULDIV_EN=1:
  - Funct3 000 MUL 1000 (low XLEN of product).
  - 011 MULHU 1001 (high XLEN).
  - 101 DIVU 1010.
  - 111 REMU 1011.
- ALUOp=00 (Funct7 ignored): same Funct3 map as R-type with Funct7=0.
- ALUOp=01: Funct3=010 gives ADD.
- Any other combination: illegal=1, operation=1111, result=0. It completes in 1 cycle like a simple op.
- Arithmetic:
  - ADD/SUB are mod 2^XLEN.
  - SLT is a signed compare; result is zero-extended 0 or 1.
  - NOR is ~(a|b).
- Acceptance occurs when in_valid && in_ready.
- FSM states IDLE, BUSY, DONE:
  - IDLE: on acceptance of a simple or illegal op, compute and register the result, then go to DONE. out_valid is high the next cycle (latency 1).
  - IDLE: on acceptance of an M op, latch the operands, clear count, go to BUSY.
  - BUSY: one shift-add (MUL/MULHU) or restoring-subtract (DIVU/REMU) step per cycle, with 2*XLEN-bit working registers. When count==XLEN-1, register the result and go to DONE. Latency from acceptance to out_valid is exactly XLEN+1 cycles.
  - DONE: out_valid=1. result, operation and illegal are held stable while out_ready=0.
  - DONE with out_ready=1: either return to IDLE, or take a new request in the same cycle (back-to-back).
- in_ready = (state==IDLE) || (state==DONE && out_ready). in_ready is 0 in BUSY.
- Divide by zero: DIVU gives all ones; REMU gives op_a. Both still take XLEN+1 cycles.
- Inputs are sampled only on acceptance. Later input changes do not affect an op in flight.
- rst_n asserted mid-BUSY or in DONE aborts the op and discards the result. No out_valid pulse follows the deassertion of reset.
- When out_valid=1 and out_ready=0, the unit stalls indefinitely with no state change.

Decomposition:
- Shared package alu_pkg holds:
  - ALUOp encodings.
  - 4-bit operation localparams (OP_AND..OP_REMU, OP_ILLEGAL=1111).
  - FSM state encoding.
  - Funct7 constants (F7_BASE, F7_ALT, F7_MULDIV).
- One natural sub-module: alu_muldiv_iter. It is the iterative shift-add/restoring-divide datapath with start/done, instantiated only under MULDIV_EN.
- Decode and the simple ALU stay in the top level.

Test Plan:
1. ALUOp=10, F7=0000000, F3=000, a=5, b=7, out_ready=1 -> out_valid next cycle, result=12, operation=0010, illegal=0.
2. ALUOp=10, F7=0100000, F3=000, a=3, b=5 -> result=0xFFFFFFFE. Then SLT with a=0xFFFFFFFF, b=1 -> result=1. Then ALUOp=01, F3=010 -> operation=0010.
3. MUL a=0xFFFFFFFF, b=2 -> out_valid exactly 33 cycles after acceptance, result=0xFFFFFFFE; in_ready=0 throughout BUSY. MULHU with the same operands -> result=1.
4. DIVU a=100, b=7 -> result=14; REMU -> 2. DIVU a=9, b=0 -> 0xFFFFFFFF; REMU a=9, b=0 -> 9.
5. ALUOp=10, F7=0000000, F3=001 -> illegal=1, operation=1111, result=0. With MULDIV_EN=0, MUL -> illegal=1 after 1 cycle.
6. out_ready held 0 for 5 cycles in DONE -> outputs stable. Back-to-back ADDs with out_ready=1 -> one result per cycle. rst_n pulsed low mid-DIVU -> out_valid=0 and no stale result after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: ALUOp classes, operation codes,
// funct7 classes and the controller state type.
package alu_pkg;

  localparam logic [1:0] ALUOP_ITYPE = 2'b00;
  localparam logic [1:0] ALUOP_LDST  = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_ADD     = 4'b0010;
  localparam logic [3:0] OP_SUB     = 4'b0110;
  localparam logic [3:0] OP_SLT     = 4'b0111;
  localparam logic [3:0] OP_MUL     = 4'b1000;
  localparam logic [3:0] OP_MULHU   = 4'b1001;
  localparam logic [3:0] OP_DIVU    = 4'b1010;
  localparam logic [3:0] OP_REMU    = 4'b1011;
  localparam logic [3:0] OP_NOR     = 4'b1100;
  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b111:  base_op = OP_AND;
      3'b110:  base_op = OP_OR;
      3'b100:  base_op = OP_NOR;
      3'b010:  base_op = OP_SLT;
      3'b000:  base_op = OP_ADD;
      default: base_op = OP_ILLEGAL;
    endcase
  endfunction

  function automatic logic [3:0] muldiv_op(input logic [2:0] f3);
    case (f3)
      3'b000:  muldiv_op = OP_MUL;
      3'b011:  muldiv_op = OP_MULHU;
      3'b101:  muldiv_op = OP_DIVU;
      3'b111:  muldiv_op = OP_REMU;
      default: muldiv_op = OP_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// done/lo/hi present the value of the final step so the caller can register it on that edge.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] hi
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [2*XLEN-1:0] acc_q, acc_step;
  logic [XLEN-1:0]   b_q;
  logic              div_q, run_q;
  logic [CW-1:0]     count_q;
  logic [XLEN:0]     mul_sum, div_shl, div_diff;

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shl  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_shl - {1'b0, b_q};
    if (!div_q) begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {div_shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      run_q   <= 1'b0;
      count_q <= '0;
    end else if (start) begin
      acc_q   <= {{XLEN{1'b0}}, a};
      b_q     <= b;
      div_q   <= is_div;
      run_q   <= 1'b1;
      count_q <= '0;
    end else if (run_q) begin
      acc_q   <= acc_step;
      count_q <= count_q + 1'b1;
      if (count_q == LAST) run_q <= 1'b0;
    end
  end

  assign done = run_q && (count_q == LAST);
  assign lo   = acc_step[XLEN-1:0];
  assign hi   = acc_step[2*XLEN-1:XLEN];

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes ALUOp/Funct7/Funct3, runs simple ops in one cycle and
// M ops through the iterative datapath, with valid/ready on both sides.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          MULDIV_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      operation,
  output logic            illegal
);

  state_e          state_q;
  logic            out_valid_q, illegal_q;
  logic [XLEN-1:0] result_q, alu_res, md_res, md_lo, md_hi;
  logic [3:0]      operation_q, dec_op;
  logic            dec_ill, dec_m, accept, md_done;

  always_comb begin
    dec_op = OP_ILLEGAL;
    case (ALUOp)
      ALUOP_RTYPE: begin
        if (Funct7 == F7_BASE) dec_op = base_op(Funct3);
        else if (Funct7 == F7_ALT && Funct3 == 3'b000) dec_op = OP_SUB;
        else if (Funct7 == F7_MULDIV && MULDIV_EN) dec_op = muldiv_op(Funct3);
      end
      ALUOP_ITYPE: dec_op = base_op(Funct3);
      ALUOP_LDST:  if (Funct3 == 3'b010) dec_op = OP_ADD;
      default:     ;
    endcase
  end

  assign dec_ill = (dec_op == OP_ILLEGAL);
  assign dec_m   = (dec_op[3:2] == 2'b10);

  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      default: alu_res = '0;
    endcase
  end

  assign in_ready = rst_n && (state_q == StIdle || (state_q == StDone && out_ready));
  assign accept   = in_valid && in_ready;

  generate
    if (MULDIV_EN) begin : g_muldiv
      alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && dec_m),
        .is_div (dec_op[1]),
        .a      (op_a),
        .b      (op_b),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
      );
    end else begin : g_no_muldiv
      assign md_done = 1'b0;
      assign md_lo   = '0;
      assign md_hi   = '0;
    end
  endgenerate

  // Quotient and low product live in the low half; remainder and high product in the high half.
  assign md_res = (operation_q == OP_MUL || operation_q == OP_DIVU) ? md_lo : md_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      operation_q <= '0;
      illegal_q   <= 1'b0;
    end else if (accept) begin
      operation_q <= dec_op;
      illegal_q   <= dec_ill;
      if (dec_m) begin
        state_q     <= StBusy;
        out_valid_q <= 1'b0;
      end else begin
        state_q     <= StDone;
        out_valid_q <= 1'b1;
        result_q    <= alu_res;
      end
    end else begin
      case (state_q)
        StBusy: if (md_done) begin
          state_q     <= StDone;
          out_valid_q <= 1'b1;
          result_q    <= md_res;
        end
        StDone: if (out_ready) begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign operation = operation_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: a driver pushes model predictions on acceptance,
// a monitor checks every presented result, its timing and the busy-side ready.
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0, in_ready, out_valid, out_ready, illegal;
  logic [1:0]      ALUOp = '0;
  logic [6:0]      Funct7 = '0;
  logic [2:0]      Funct3 = '0;
  logic [XLEN-1:0] op_a = '0, op_b = '0, result;
  logic [3:0]      operation;
  logic            in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1, illegal2;
  logic [XLEN-1:0] result2;
  logic [3:0]      operation2;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(XLEN), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ALUOp(ALUOp),
    .Funct7(Funct7), .Funct3(Funct3), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .operation(operation), .illegal(illegal)
  );

  alu_exec_unit #(.XLEN(XLEN), .MULDIV_EN(1'b0)) dut_nomd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .ALUOp(ALUOp),
    .Funct7(Funct7), .Funct3(Funct3), .op_a(op_a), .op_b(op_b), .out_valid(out_valid2),
    .out_ready(out_ready2), .result(result2), .operation(operation2), .illegal(illegal2)
  );

  // gap = clock edges from the accepting edge to the edge that raises out_valid.
  typedef struct {
    logic [XLEN-1:0] res;
    logic [3:0]      op;
    logic            ill;
    int              gap;
    int              acc;
  } exp_t;

  typedef enum {K_BAD, K_AND, K_OR, K_NOR, K_SLT, K_ADD, K_SUB,
                K_MUL, K_MULHU, K_DIVU, K_REMU} kind_e;

  exp_t q[$];
  int   n_cmp = 0, n_fail = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0, force_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic kind_e base_kind(input logic [2:0] f3);
    case (f3)
      3'd7:    return K_AND;
      3'd6:    return K_OR;
      3'd4:    return K_NOR;
      3'd2:    return K_SLT;
      3'd0:    return K_ADD;
      default: return K_BAD;
    endcase
  endfunction

  function automatic exp_t model(input logic [1:0] aluop, input logic [6:0] f7,
                                 input logic [2:0] f3, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input bit md);
    exp_t        e;
    kind_e       k = K_BAD;
    logic [63:0] p = 64'(a) * 64'(b);
    if (aluop == 2'd2 && f7 == 7'h00) k = base_kind(f3);
    else if (aluop == 2'd2 && f7 == 7'h20 && f3 == 3'd0) k = K_SUB;
    else if (aluop == 2'd2 && f7 == 7'h01 && md) begin
      if (f3 == 3'd0) k = K_MUL;
      else if (f3 == 3'd3) k = K_MULHU;
      else if (f3 == 3'd5) k = K_DIVU;
      else if (f3 == 3'd7) k = K_REMU;
    end else if (aluop == 2'd0) k = base_kind(f3);
    else if (aluop == 2'd1 && f3 == 3'd2) k = K_ADD;
    e.gap = 0; e.ill = 1'b0; e.acc = 0;
    case (k)
      K_AND:   begin e.op = 4'h0; e.res = a & b; end
      K_OR:    begin e.op = 4'h1; e.res = a | b; end
      K_NOR:   begin e.op = 4'hC; e.res = ~(a | b); end
      K_SLT:   begin e.op = 4'h7; e.res = ($signed(a) < $signed(b)) ? 1 : 0; end
      K_ADD:   begin e.op = 4'h2; e.res = a + b; end
      K_SUB:   begin e.op = 4'h6; e.res = a - b; end
      K_MUL:   begin e.op = 4'h8; e.res = p[31:0]; e.gap = XLEN; end
      K_MULHU: begin e.op = 4'h9; e.res = p[63:32]; e.gap = XLEN; end
      K_DIVU:  begin e.op = 4'hA; e.res = (b == 0) ? '1 : a / b; e.gap = XLEN; end
      K_REMU:  begin e.op = 4'hB; e.res = (b == 0) ? a : a % b; e.gap = XLEN; end
      default: begin e.op = 4'hF; e.res = '0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (force_stall) out_ready = 1'b0;
      else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
    end
  end

  // Monitor: compares the presented result against the head of the scoreboard every cycle.
  initial begin
    bit fresh = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        fresh = 1'b1;
      end else if (!out_valid) begin
        if (q.size() > 0) check("busy_in_ready", in_ready, 0);
      end else if (q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_out_valid: got 1, required 0 (no request outstanding)");
      end else begin
        if (fresh) begin
          check("latency_edges", cyc - q[0].acc, q[0].gap);
          fresh = 1'b0;
        end
        check("result", result, q[0].res);
        check("operation", operation, q[0].op);
        check("illegal", illegal, q[0].ill);
        if (out_ready) begin
          void'(q.pop_front());
          fresh = 1'b1;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] aluop, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, output int acc_at);
    bit   taken = 1'b0;
    exp_t e;
    acc_at = -1;
    @(negedge clk);
    ALUOp = aluop; Funct7 = f7; Funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
    for (int t = 0; t < 400 && !taken; t++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        #1;
        e = model(aluop, f7, f3, a, b, 1'b1);
        e.acc = cyc;
        q.push_back(e);
        acc_at = cyc;
        taken = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!taken) begin
      n_cmp++; n_fail++;
      $display("FAIL issue_timeout: in_ready stayed 0, required 1");
    end
    // Scramble inputs after acceptance; the op in flight must not see them.
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; Funct3 = 3'($urandom);
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && q.size() > 0; t++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic issue_nomd(input logic [1:0] aluop, input logic [6:0] f7, input logic [2:0] f3,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    exp_t e = model(aluop, f7, f3, a, b, 1'b0);
    @(negedge clk);
    ALUOp = aluop; Funct7 = f7; Funct3 = f3; op_a = a; op_b = b; in_valid2 = 1'b1;
    #1 check("nomd_in_ready", in_ready2, 1);
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    @(negedge clk);
    check("nomd_out_valid", out_valid2, 1);
    check("nomd_result", result2, e.res);
    check("nomd_operation", operation2, e.op);
    check("nomd_illegal", illegal2, e.ill);
  endtask

  initial begin
    int acc0, acc1;
    #12;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_operation", operation, 0);
    check("reset_illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(2'b10, 7'h00, 3'd0, 32'd5, 32'd7, acc0);
    issue(2'b10, 7'h20, 3'd0, 32'd3, 32'd5, acc0);
    issue(2'b10, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1, acc0);
    issue(2'b01, 7'h55, 3'd2, 32'd100, 32'd24, acc0);
    issue(2'b10, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'd2, acc0);
    issue(2'b10, 7'h01, 3'd3, 32'hFFFF_FFFF, 32'd2, acc0);
    issue(2'b10, 7'h01, 3'd5, 32'd100, 32'd7, acc0);
    issue(2'b10, 7'h01, 3'd7, 32'd100, 32'd7, acc0);
    issue(2'b10, 7'h01, 3'd5, 32'd9, 32'd0, acc0);
    issue(2'b10, 7'h01, 3'd7, 32'd9, 32'd0, acc0);
    issue(2'b10, 7'h00, 3'd1, 32'd9, 32'd4, acc0);
    issue(2'b00, 7'h7F, 3'd4, 32'h0F0F_0000, 32'h0000_00F0, acc0);
    drain();

    force_stall = 1'b1;
    issue(2'b10, 7'h00, 3'd6, 32'hA5A5_0000, 32'h0000_5A5A, acc0);
    repeat (6) @(negedge clk);
    force_stall = 1'b0;
    drain();

    issue(2'b10, 7'h00, 3'd0, 32'd1, 32'd2, acc0);
    issue(2'b10, 7'h00, 3'd0, 32'd3, 32'd4, acc1);
    issue(2'b10, 7'h00, 3'd0, 32'd5, 32'd6, acc1);
    issue(2'b10, 7'h00, 3'd0, 32'd7, 32'd8, acc1);
    check("back_to_back_edges", acc1 - acc0, 3);
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      logic [1:0] aluop;
      logic [6:0] f7;
      logic [XLEN-1:0] b;
      case ($urandom_range(0, 5))
        0, 1, 2: aluop = 2'b10;
        3:       aluop = 2'b00;
        4:       aluop = 2'b01;
        default: aluop = 2'b11;
      endcase
      case ($urandom_range(0, 5))
        0, 1:    f7 = 7'h00;
        2:       f7 = 7'h20;
        3, 4:    f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      issue(aluop, f7, 3'($urandom), $urandom, b, acc0);
    end
    drain();
    rand_ready = 1'b0;

    // Reset in the middle of a divide: the result must never appear.
    issue(2'b10, 7'h01, 3'd5, 32'd1000, 32'd3, acc0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("midop_reset_out_valid", out_valid, 0);
    check("midop_reset_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    check("midop_reset_result", result, 0);
    check("midop_reset_operation", operation, 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    issue_nomd(2'b10, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'd2);
    issue_nomd(2'b10, 7'h00, 3'd0, 32'd5, 32'd7);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end

endmodule
